dmr_retry_ctrl: RTL and testbench

//  Retry sequencer for a DMR stream fork. Watches the fork's ready-disagreement error
//  and a downstream replica-compare mismatch, then drives the fork's repeat input.

---
 rtl/dmr_retry_ctrl.sv | 138 +++++++++++++
 tb/tb_dmr_retry_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmr_retry_ctrl.sv
// Retry sequencer for a DMR stream fork: bounded repeat requests, then a sticky fatal stall.
// Optional fault statistics counter enabled by defining DMR_RETRY_STATS_EN.
module dmr_retry_ctrl #(
  parameter int unsigned MAX_RETRIES = 3,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned CNT_W       = 16,
  localparam int unsigned RetryW = (MAX_RETRIES == 0) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fork_error_i,
  input  logic              mismatch_i,
  input  logic              hs_i,
  input  logic              clear_fatal_i,
  output logic              repeat_o,
  output logic              busy_o,
  output logic              fatal_o,
  output logic [RetryW-1:0] retry_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam int unsigned HoldW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HoldW-1:0]  HoldLoad = HoldW'(HOLD_CYCLES);
  localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRIES);

  typedef enum logic [1:0] {StIdle, StRepeat, StCheck, StFatal} state_e;

  state_e             state_q, state_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [RetryW-1:0]  retry_q, retry_d;
  logic               repeat_q, repeat_d;
  logic               busy_q, busy_d;
  logic               fatal_q, fatal_d;
  logic               fault;

  assign fault = fork_error_i | mismatch_i;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    retry_d = retry_q;
    case (state_q)
      StIdle: begin
        if (fault) begin
          if (MAX_RETRIES == 0) begin
            state_d = StFatal;
          end else begin
            state_d = StRepeat;
            retry_d = RetryW'(1);
            hold_d  = HoldLoad;
          end
        end
      end
      StRepeat: begin
        // Faults and handshakes are ignored while the fork is replaying.
        if (hold_q <= HoldW'(1)) begin
          state_d = StCheck;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end
      StCheck: begin
        if (fault) begin
          if (retry_q == MaxRetry) begin
            state_d = StFatal;
          end else begin
            state_d = StRepeat;
            retry_d = retry_q + RetryW'(1);
            hold_d  = HoldLoad;
          end
        end else if (hs_i) begin
          state_d = StIdle;
          retry_d = '0;
        end
      end
      StFatal: begin
        if (clear_fatal_i) begin
          state_d = StIdle;
          retry_d = '0;
          hold_d  = '0;
        end
      end
      default: state_d = StFatal;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    repeat_d = (state_d == StRepeat) || (state_d == StFatal);
    busy_d   = (state_d != StIdle);
    fatal_d  = (state_d == StFatal);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      hold_q   <= '0;
      retry_q  <= '0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
      fatal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      retry_q  <= retry_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
      fatal_q  <= fatal_d;
    end
  end

  assign repeat_o    = repeat_q;
  assign busy_o      = busy_q;
  assign fatal_o     = fatal_q;
  assign retry_cnt_o = retry_q;

`ifdef DMR_RETRY_STATS_EN
  logic             act_fault;
  logic [CNT_W-1:0] err_cnt_q;

  // Only IDLE and CHECK act on a fault; every fault there causes a transition.
  assign act_fault = fault && ((state_q == StIdle) || (state_q == StCheck));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (act_fault && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dmr_retry_ctrl.sv
// Directed bench for dmr_retry_ctrl: three instances (defaults, long hold / narrow counter,
// zero retries) share one stimulus stream; each test checks the instance it targets.
module tb_dmr_retry_ctrl;

`ifdef DMR_RETRY_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, fork_error, mismatch, hs, clear_fatal;

  logic        rep0, busy0, fatal0;
  logic [1:0]  retry0;
  logic [15:0] err0;
  logic        rep1, busy1, fatal1;
  logic [1:0]  retry1;
  logic [1:0]  err1;
  logic        rep2, busy2, fatal2;
  logic [0:0]  retry2;
  logic [15:0] err2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmr_retry_ctrl dut0 (
    .clk_i(clk), .rst_i(rst), .fork_error_i(fork_error), .mismatch_i(mismatch), .hs_i(hs),
    .clear_fatal_i(clear_fatal), .repeat_o(rep0), .busy_o(busy0), .fatal_o(fatal0),
    .retry_cnt_o(retry0), .err_cnt_o(err0)
  );

  dmr_retry_ctrl #(.MAX_RETRIES(3), .HOLD_CYCLES(4), .CNT_W(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .fork_error_i(fork_error), .mismatch_i(mismatch), .hs_i(hs),
    .clear_fatal_i(clear_fatal), .repeat_o(rep1), .busy_o(busy1), .fatal_o(fatal1),
    .retry_cnt_o(retry1), .err_cnt_o(err1)
  );

  dmr_retry_ctrl #(.MAX_RETRIES(0), .HOLD_CYCLES(1), .CNT_W(16)) dut2 (
    .clk_i(clk), .rst_i(rst), .fork_error_i(fork_error), .mismatch_i(mismatch), .hs_i(hs),
    .clear_fatal_i(clear_fatal), .repeat_o(rep2), .busy_o(busy2), .fatal_o(fatal2),
    .retry_cnt_o(retry2), .err_cnt_o(err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    fork_error = 1'b0; mismatch = 1'b0; hs = 1'b0; clear_fatal = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fork_error = 1'b0; mismatch = 1'b0; hs = 1'b0; clear_fatal = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({rep0, busy0, fatal0, retry0, err0} !== 21'd0) begin
      errors++; $display("FAIL reset_state: got %0h expected 0", {rep0, busy0, fatal0, retry0, err0});
    end
    step();
    rst = 1'b0;
    step();
    mismatch = 1'b1;
    step();
    mismatch = 1'b0;
    checks++;
    if (rep1 !== 1'b1) begin errors++; $display("FAIL reset_pre_rep: got %0b expected 1", rep1); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rep1, busy1, fatal1, retry1} !== 5'd0) begin
      errors++; $display("FAIL reset_async: got %0h expected 0", {rep1, busy1, fatal1, retry1});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    checks++;
    if ({rep0, busy0, rep1, busy1} !== 4'd0) begin
      errors++; $display("FAIL reset_release: got %0h expected 0", {rep0, busy0, rep1, busy1});
    end
  endtask

  task automatic test_single_fault();
    do_reset();
    step();
    mismatch = 1'b1;
    step();
    mismatch = 1'b0;
    checks++;
    if ({rep0, busy0, retry0} !== 4'b11_01) begin
      errors++; $display("FAIL single_repeat: got %b expected 1101", {rep0, busy0, retry0});
    end
    step();
    checks++;
    if ({rep0, busy0, retry0} !== 4'b01_01) begin
      errors++; $display("FAIL single_check: got %b expected 0101", {rep0, busy0, retry0});
    end
    step();
    hs = 1'b1;
    step();
    hs = 1'b0;
    checks++;
    if ({rep0, busy0, fatal0, retry0} !== 5'd0) begin
      errors++; $display("FAIL single_idle: got %b expected 00000", {rep0, busy0, fatal0, retry0});
    end
    checks++;
    if (err0 !== 16'(Stats ? 1 : 0)) begin
      errors++; $display("FAIL single_err_cnt: got %0d expected %0d", err0, Stats ? 1 : 0);
    end
  endtask

  task automatic test_escalation();
    int exp_rep[9]   = '{1, 0, 1, 0, 1, 0, 1, 1, 1};
    int exp_retry[9] = '{1, 1, 2, 2, 3, 3, 3, 3, 3};
    int exp_fatal[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    do_reset();
    fork_error = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (int'(rep0) != exp_rep[i] || int'(retry0) != exp_retry[i]
          || int'(fatal0) != exp_fatal[i] || $isunknown({rep0, retry0, fatal0})) begin
        errors++;
        $display("FAIL escalate_step%0d: got rep=%b retry=%0d fatal=%b expected rep=%0d retry=%0d fatal=%0d",
                 i, rep0, retry0, fatal0, exp_rep[i], exp_retry[i], exp_fatal[i]);
      end
      checks++;
      if ({rep2, fatal2} !== 2'b11) begin
        errors++; $display("FAIL maxzero_cont%0d: got %b expected 11", i, {rep2, fatal2});
      end
    end
    for (int i = 0; i < 11; i++) step();
    checks++;
    if ({rep1, fatal1, retry1} !== 4'b11_11) begin
      errors++; $display("FAIL hold4_fatal: got %b expected 1111", {rep1, fatal1, retry1});
    end
    checks++;
    if (err1 !== 2'(Stats ? 3 : 0)) begin
      errors++; $display("FAIL err_saturate: got %0d expected %0d", err1, Stats ? 3 : 0);
    end
    checks++;
    if (err0 !== 16'(Stats ? 4 : 0)) begin
      errors++; $display("FAIL escalate_err_cnt: got %0d expected %0d", err0, Stats ? 4 : 0);
    end
    checks++;
    if (err2 !== 16'(Stats ? 1 : 0)) begin
      errors++; $display("FAIL maxzero_err_cnt: got %0d expected %0d", err2, Stats ? 1 : 0);
    end
  endtask

  task automatic test_fatal_clear();
    clear_fatal = 1'b1;
    step();
    clear_fatal = 1'b0;
    fork_error  = 1'b0;
    checks++;
    if ({rep0, busy0, fatal0, retry0} !== 5'd0) begin
      errors++; $display("FAIL clear_fatal: got %b expected 00000", {rep0, busy0, fatal0, retry0});
    end
    step();
    checks++;
    if ({rep0, busy0} !== 2'b00) begin
      errors++; $display("FAIL clear_fault_ignored: got %b expected 00", {rep0, busy0});
    end
    checks++;
    if (err0 !== 16'(Stats ? 4 : 0)) begin
      errors++; $display("FAIL clear_err_cnt: got %0d expected %0d", err0, Stats ? 4 : 0);
    end
    clear_fatal = 1'b1;
    step();
    clear_fatal = 1'b0;
    checks++;
    if ({rep0, busy0, fatal0} !== 3'b000) begin
      errors++; $display("FAIL clear_in_idle: got %b expected 000", {rep0, busy0, fatal0});
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    mismatch = 1'b1;
    step();
    mismatch = 1'b0;
    step();
    checks++;
    if ({rep0, busy0} !== 2'b01) begin
      errors++; $display("FAIL simul_in_check: got %b expected 01", {rep0, busy0});
    end
    mismatch = 1'b1;
    hs = 1'b1;
    step();
    mismatch = 1'b0;
    hs = 1'b0;
    checks++;
    if ({rep0, busy0, retry0} !== 4'b11_10) begin
      errors++; $display("FAIL simul_fault_wins: got %b expected 1110", {rep0, busy0, retry0});
    end
  endtask

  task automatic test_hold_cycles();
    int cnt = 0;
    int edges = 0;
    logic prev = 1'b0;
    do_reset();
    fork_error = 1'b1;
    step();
    fork_error = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rep1 === 1'b1) cnt++;
      if (rep1 === 1'b1 && prev === 1'b0) edges++;
      prev = rep1;
      if (i < 9) step();
    end
    checks++;
    if (cnt != 4 || edges != 1) begin
      errors++; $display("FAIL hold4_width: got %0d cycles in %0d pulses expected 4 in 1", cnt, edges);
    end
    checks++;
    if ({rep1, busy1, retry1} !== 4'b01_01) begin
      errors++; $display("FAIL hold4_check: got %b expected 0101", {rep1, busy1, retry1});
    end
  endtask

  task automatic test_max_zero();
    do_reset();
    mismatch = 1'b1;
    step();
    mismatch = 1'b0;
    checks++;
    if ({rep2, busy2, fatal2, retry2} !== 4'b1110) begin
      errors++; $display("FAIL maxzero_first: got %b expected 1110", {rep2, busy2, fatal2, retry2});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (rep2 !== fatal2 || fatal2 !== 1'b1) begin
        errors++; $display("FAIL maxzero_hold%0d: got rep=%b fatal=%b expected 1 1", i, rep2, fatal2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_fault();
    test_escalation();
    test_fatal_clear();
    test_simultaneous();
    test_hold_cycles();
    test_max_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
